// File: rtl/simmem_multichan_delay_buf_if.sv
// Handshake bundle for simmem_multichan_delay_buf: per-channel push side plus merged release side.
// master drives pushes and out_ready_i; slave is the delay buffer itself.
interface simmem_multichan_delay_buf_if #(
  parameter int NumChan = 2,
  parameter int DataW   = 32,
  parameter int DelayW  = 8,
  parameter int ChanW   = (NumChan > 1) ? $clog2(NumChan) : 1
);
  logic [NumChan-1:0]        in_valid_i;
  logic [NumChan-1:0]        in_ready_o;
  logic [NumChan*DataW-1:0]  in_data_i;
  logic [NumChan*DelayW-1:0] in_delay_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [DataW-1:0]          out_data_o;
  logic [ChanW-1:0]          out_chan_o;

  modport master (
    output in_valid_i, in_data_i, in_delay_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_chan_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_delay_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_chan_o
  );
endinterface

// File: rtl/simmem_multichan_delay_buf.sv
// Per-channel delay FIFOs (release delay+1 cycles after accept) merged by a locked round-robin arbiter;
// input ready ignores out_ready_i. Optional counters under SIMMEM_DELAY_STATS_EN.
module simmem_multichan_delay_buf #(
  parameter int NumChan = 2,
  parameter int DataW   = 32,
  parameter int Depth   = 8,
  parameter int DelayW  = 8,
  parameter int ChanW   = (NumChan > 1) ? $clog2(NumChan) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 en_i,
  simmem_multichan_delay_buf_if.slave          bus,
  output logic [NumChan*($clog2(Depth)+1)-1:0] occ_o
`ifdef SIMMEM_DELAY_STATS_EN
  ,
  output logic [NumChan*16-1:0]                stat_rel_o,
  output logic [15:0]                          stat_stall_o
`endif
);
  localparam int IdxW = $clog2(Depth);
  localparam int PtrW = IdxW + 1;

  logic [DataW-1:0]   r_mem [NumChan][Depth];
  logic [DelayW-1:0]  r_cnt [NumChan][Depth];
  logic [PtrW-1:0]    r_wr  [NumChan];
  logic [PtrW-1:0]    r_rd  [NumChan];
  logic               r_vld;
  logic [ChanW-1:0]   r_gnt;
  logic [ChanW-1:0]   r_rr;

  logic [NumChan-1:0] w_full;
  logic [NumChan-1:0] w_rdy;
  logic [NumChan-1:0] w_push;
  logic [NumChan-1:0] w_pop;
  logic [NumChan-1:0] w_elig;
  logic [PtrW-1:0]    w_occ  [NumChan];
  logic [IdxW-1:0]    w_hidx [NumChan];
  logic               w_hs;
  logic               w_sel_vld;
  logic [ChanW-1:0]   w_sel;
  logic [ChanW-1:0]   w_base;
  logic [ChanW-1:0]   w_rr_nxt;

  // A channel being popped this cycle is judged on its next entry, so releases can go back-to-back.
  always_comb begin
    w_hs     = r_vld & bus.out_ready_i;
    w_rr_nxt = (r_gnt == ChanW'(NumChan - 1)) ? '0 : r_gnt + 1'b1;
    for (int c = 0; c < NumChan; c++) begin
      w_occ[c]  = r_wr[c] - r_rd[c];
      w_full[c] = (r_wr[c][IdxW-1:0] == r_rd[c][IdxW-1:0]) && (r_wr[c][IdxW] != r_rd[c][IdxW]);
      w_rdy[c]  = en_i & ~w_full[c] & ~rst_i;
      w_push[c] = bus.in_valid_i[c] & w_rdy[c];
      w_pop[c]  = w_hs && (r_gnt == ChanW'(c));
      w_hidx[c] = r_rd[c][IdxW-1:0] + IdxW'(w_pop[c]);
      w_elig[c] = (w_occ[c] != PtrW'(w_pop[c])) && (r_cnt[c][w_hidx[c]] == '0);
    end
  end

  always_comb begin
    int best_d;
    int d;
    w_sel_vld = 1'b0;
    w_sel     = '0;
    w_base    = w_hs ? w_rr_nxt : r_rr;
    best_d    = NumChan;
    d         = 0;
    for (int c = 0; c < NumChan; c++) begin
      d = (c >= int'(w_base)) ? c - int'(w_base) : c + NumChan - int'(w_base);
      if (w_elig[c] && d < best_d) begin
        best_d    = d;
        w_sel     = ChanW'(c);
        w_sel_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NumChan; c++) begin
        r_wr[c] <= '0;
        r_rd[c] <= '0;
      end
      r_vld <= 1'b0;
      r_gnt <= '0;
      r_rr  <= '0;
    end else begin
      for (int c = 0; c < NumChan; c++) begin
        r_wr[c] <= r_wr[c] + PtrW'(w_push[c]);
        r_rd[c] <= r_rd[c] + PtrW'(w_pop[c]);
      end
      // Grant stays locked until its handshake completes.
      if (!r_vld || w_hs) begin
        r_vld <= w_sel_vld;
        r_gnt <= w_sel;
      end
      if (w_hs) begin
        r_rr <= w_rr_nxt;
      end
    end
  end

  // Slot contents are only meaningful between the pointers, so storage needs no reset.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NumChan; c++) begin
      for (int e = 0; e < Depth; e++) begin
        if (w_push[c] && (r_wr[c][IdxW-1:0] == IdxW'(e))) begin
          r_mem[c][e] <= bus.in_data_i[c*DataW +: DataW];
          r_cnt[c][e] <= bus.in_delay_i[c*DelayW +: DelayW];
        end else if (r_cnt[c][e] != '0) begin
          r_cnt[c][e] <= r_cnt[c][e] - 1'b1;
        end
      end
    end
  end

  assign bus.in_ready_o  = w_rdy;
  assign bus.out_valid_o = r_vld;
  assign bus.out_chan_o  = r_vld ? r_gnt : '0;
  assign bus.out_data_o  = r_vld ? r_mem[r_gnt][r_rd[r_gnt][IdxW-1:0]] : '0;

  always_comb begin
    occ_o = '0;
    for (int c = 0; c < NumChan; c++) begin
      occ_o[c*PtrW +: PtrW] = w_occ[c];
    end
  end

`ifdef SIMMEM_DELAY_STATS_EN
  logic [15:0] r_rel [NumChan];
  logic [15:0] r_stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NumChan; c++) begin
        r_rel[c] <= '0;
      end
      r_stall <= '0;
    end else begin
      for (int c = 0; c < NumChan; c++) begin
        if (w_pop[c] && (r_rel[c] != 16'hFFFF)) begin
          r_rel[c] <= r_rel[c] + 16'd1;
        end
      end
      if (r_vld && !bus.out_ready_i && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end
    end
  end

  always_comb begin
    stat_rel_o = '0;
    for (int c = 0; c < NumChan; c++) begin
      stat_rel_o[c*16 +: 16] = r_rel[c];
    end
  end

  assign stat_stall_o = r_stall;
`endif
endmodule
